// File: rtl/mul_frame_pkg.sv
// Shared types and constants for the multiplier framing controller.
package mul_frame_pkg;

    // Controller states, from idle through request assembly to response transmission
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPC,
        ST_OPA,
        ST_OPB,
        ST_MUL,
        ST_TX_HDR,
        ST_TX_DAT,
        ST_TX_ERR
    } state_t;

    // Request opcodes
    localparam logic [7:0] OP_UMUL  = 8'h00;
    localparam logic [7:0] OP_SMUL  = 8'h01;
    localparam logic [7:0] OP_SQR   = 8'h02;

    // Payload byte of the error response frame
    localparam logic [7:0] ERR_BYTE = 8'hEE;

    // True for the opcodes the controller knows how to execute
    function automatic logic opcode_ok(input logic [7:0] op);
        return (op == OP_UMUL) || (op == OP_SMUL) || (op == OP_SQR);
    endfunction

endpackage

// File: rtl/mul_core.sv
// Registered OP_WIDTH x OP_WIDTH multiplier; full 2*OP_WIDTH-bit product one cycle after en.
module mul_core #(
    parameter int OP_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    is_signed,
    input  logic [OP_WIDTH-1:0]     a,
    input  logic [OP_WIDTH-1:0]     b,
    output logic [2*OP_WIDTH-1:0]   p
);

    localparam int PW = 2 * OP_WIDTH;

    logic [PW-1:0] a_zx;
    logic [PW-1:0] b_zx;
    logic [PW-1:0] a_sx;
    logic [PW-1:0] b_sx;

    // Widening both operands to the product width lets one plain multiply serve both modes:
    // the low PW bits of a sign-extended product are the exact two's complement result.
    assign a_zx = {{OP_WIDTH{1'b0}}, a};
    assign b_zx = {{OP_WIDTH{1'b0}}, b};
    assign a_sx = {{OP_WIDTH{a[OP_WIDTH-1]}}, a};
    assign b_sx = {{OP_WIDTH{b[OP_WIDTH-1]}}, b};

    // Capture the product whenever the controller requests a multiply
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p <= '0;
        end else if (en) begin
            p <= is_signed ? (a_sx * b_sx) : (a_zx * b_zx);
        end
    end

endmodule

// File: rtl/mul_frame_ctrl.sv
// Byte-stream framing controller: assembles multiply requests from rx bytes, runs the
// multiplier and returns the product as a response frame over the tx handshake.
module mul_frame_ctrl
    import mul_frame_pkg::*;
#(
    parameter int         OP_WIDTH       = 8,
    parameter logic [7:0] REQ_SOF        = 8'hA5,
    parameter logic [7:0] RSP_SOF        = 8'h5A,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic       clk_int,
    input  logic       reset,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_byte,
    output logic       tx_start,
    output logic       busy,
    output logic       frame_done,
    output logic       err_pulse
);

    localparam int N     = OP_WIDTH / 8;
    localparam int NB    = 2 * N;
    localparam int PW    = 2 * OP_WIDTH;
    localparam int CNT_W = 4;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 2);

    state_t              state_q, state_d;
    logic [7:0]          opcode_q, opcode_d;
    logic [OP_WIDTH-1:0] a_q, a_d;
    logic [OP_WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                hold_q, hold_d;
    logic [7:0]          tx_byte_q, tx_byte_d;

    logic                core_en;
    logic [PW-1:0]       product;
    logic [7:0]          dat_byte;
    logic [7:0]          cur_byte;
    logic                tx_ok;
    logic                in_req;
    logic                expire;
    logic [OP_WIDTH-1:0] shifted_in;

    mul_core #(
        .OP_WIDTH (OP_WIDTH)
    ) u_core (
        .clk       (clk_int),
        .rst_n     (reset),
        .en        (core_en),
        .is_signed (opcode_q == OP_SMUL),
        .a         (a_q),
        .b         (b_q),
        .p         (product)
    );

    // The cycle after a tx_start belongs to the transmitter, so tx_ready is not trusted then
    assign tx_ok      = tx_ready && !hold_q;
    assign in_req     = (state_q == ST_OPC) || (state_q == ST_OPA) || (state_q == ST_OPB);
    // A byte arriving on the expiry cycle wins over the timeout
    assign expire     = (TIMEOUT_CYCLES != 0) && in_req && !rx_valid &&
                        (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    // Operands arrive MSB first, so each new byte shifts in at the bottom
    assign shifted_in = OP_WIDTH'({a_q, rx_byte});
    assign busy       = (state_q != ST_IDLE);
    // The byte being started is shown directly; afterwards the registered copy holds it stable
    assign tx_byte    = tx_start ? cur_byte : tx_byte_q;

    // Select the product byte addressed by the transmit counter, most significant first
    always_comb begin
        dat_byte = '0;
        for (int i = 0; i < NB; i++) begin
            if (cnt_q == CNT_W'(NB - 1 - i)) begin
                dat_byte = product[8*i +: 8];
            end
        end
    end

    // State register and datapath registers
    always_ff @(posedge clk_int or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            opcode_q  <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            hold_q    <= 1'b0;
            tx_byte_q <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            hold_q    <= hold_d;
            tx_byte_q <= tx_byte_d;
        end
    end

    // Next-state logic, operand assembly and transmit handshake
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        a_d        = a_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        tmo_d      = '0;
        hold_d     = 1'b0;
        tx_byte_d  = tx_byte_q;
        tx_start   = 1'b0;
        frame_done = 1'b0;
        err_pulse  = 1'b0;
        core_en    = 1'b0;
        cur_byte   = '0;

        if (in_req && !rx_valid) begin
            tmo_d = tmo_q + TW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rx_valid && (rx_byte == REQ_SOF)) begin
                    a_d     = '0;
                    b_d     = '0;
                    state_d = ST_OPC;
                end
            end

            ST_OPC: begin
                if (expire) begin
                    err_pulse = 1'b1;
                    state_d   = ST_IDLE;
                end else if (rx_valid) begin
                    cnt_d = '0;
                    if (opcode_ok(rx_byte)) begin
                        opcode_d = rx_byte;
                        state_d  = ST_OPA;
                    end else begin
                        err_pulse = 1'b1;
                        state_d   = ST_TX_ERR;
                    end
                end
            end

            ST_OPA: begin
                if (expire) begin
                    err_pulse = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else if (rx_valid) begin
                    a_d   = shifted_in;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N - 1)) begin
                        cnt_d = '0;
                        if (opcode_q == OP_SQR) begin
                            b_d     = shifted_in;
                            state_d = ST_MUL;
                        end else begin
                            state_d = ST_OPB;
                        end
                    end
                end
            end

            ST_OPB: begin
                if (expire) begin
                    err_pulse = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else if (rx_valid) begin
                    b_d   = OP_WIDTH'({b_q, rx_byte});
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_MUL;
                    end
                end
            end

            ST_MUL: begin
                core_en = 1'b1;
                cnt_d   = '0;
                state_d = ST_TX_HDR;
            end

            ST_TX_HDR: begin
                cur_byte = RSP_SOF;
                if (tx_ok) begin
                    tx_start = 1'b1;
                    hold_d   = 1'b1;
                    state_d  = ST_TX_DAT;
                end
            end

            ST_TX_DAT: begin
                cur_byte = dat_byte;
                if (tx_ok) begin
                    tx_start = 1'b1;
                    hold_d   = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NB - 1)) begin
                        frame_done = 1'b1;
                        cnt_d      = '0;
                        state_d    = ST_IDLE;
                    end
                end
            end

            ST_TX_ERR: begin
                cur_byte = (cnt_q == '0) ? RSP_SOF : ERR_BYTE;
                if (tx_ok) begin
                    tx_start = 1'b1;
                    hold_d   = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (tx_start) begin
            tx_byte_d = cur_byte;
        end
    end

endmodule

// File: tb/tb_mul_frame_ctrl.sv
// Scoreboard bench for mul_frame_ctrl: an 8-bit instance (short timeout) and a 16-bit instance.
module tb_mul_frame_ctrl;

    typedef struct {
        logic [7:0] data;
        bit         last;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;

    logic [7:0] rx_byte8  = '0, rx_byte16  = '0;
    logic       rx_valid8 = 1'b0, rx_valid16 = 1'b0;
    logic       tx_ready8 = 1'b1, tx_ready16 = 1'b1;
    logic [7:0] tx_byte8, tx_byte16;
    logic       tx_start8, tx_start16, busy8, busy16;
    logic       frame_done8, frame_done16, err8, err16;

    exp_t       q8[$];
    exp_t       q16[$];
    exp_t       e8, e16;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         starts8  = 0, starts16 = 0;
    int         frames8  = 0, frames16 = 0;
    int         errs8    = 0, errs16   = 0;
    int         exp_frames[2];
    int         exp_errs[2];
    logic [7:0] held8, held16;
    bit         started8 = 0, started16 = 0;
    bit         stall8   = 0;

    mul_frame_ctrl #(.OP_WIDTH(8), .TIMEOUT_CYCLES(16)) u_dut8 (
        .clk_int(clk), .reset(rst_n), .rx_byte(rx_byte8), .rx_valid(rx_valid8),
        .tx_ready(tx_ready8), .tx_byte(tx_byte8), .tx_start(tx_start8), .busy(busy8),
        .frame_done(frame_done8), .err_pulse(err8)
    );

    mul_frame_ctrl #(.OP_WIDTH(16)) u_dut16 (
        .clk_int(clk), .reset(rst_n), .rx_byte(rx_byte16), .rx_valid(rx_valid16),
        .tx_ready(tx_ready16), .tx_byte(tx_byte16), .tx_start(tx_start16), .busy(busy16),
        .frame_done(frame_done16), .err_pulse(err16)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: product from the arithmetic definition of each opcode
    function automatic longint model(input int w, input int op, input longint a, input longint b);
        longint m, sa, sb, bb;
        m  = (longint'(1) << (2 * w)) - 1;
        bb = (op == 2) ? a : b;
        if (op == 1) begin
            sa = (a  >= (longint'(1) << (w - 1))) ? a  - (longint'(1) << w) : a;
            sb = (bb >= (longint'(1) << (w - 1))) ? bb - (longint'(1) << w) : bb;
            return (sa * sb) & m;
        end
        return (a * bb) & m;
    endfunction

    task automatic push(input int d, input logic [7:0] data, input bit last);
        exp_t e;
        e.data = data;
        e.last = last;
        if (d == 0) q8.push_back(e);
        else        q16.push_back(e);
    endtask

    task automatic push_frame(input int d, input int op, input longint a, input longint b);
        int     n;
        longint p;
        n = (d == 0) ? 1 : 2;
        p = model(8 * n, op, a, b);
        push(d, 8'h5A, 0);
        for (int i = 2 * n - 1; i >= 0; i--) push(d, 8'(p >> (8 * i)), i == 0);
        exp_frames[d]++;
    endtask

    task automatic send_byte(input int d, input logic [7:0] b);
        @(posedge clk); #1;
        if (d == 0) begin rx_byte8 = b; rx_valid8 = 1'b1; end
        else        begin rx_byte16 = b; rx_valid16 = 1'b1; end
        @(posedge clk); #1;
        rx_valid8  = 1'b0;
        rx_valid16 = 1'b0;
    endtask

    task automatic applyStimulus(input int d, input int op, input longint a, input longint b);
        int n;
        n = (d == 0) ? 1 : 2;
        push_frame(d, op, a, b);
        send_byte(d, 8'hA5);
        send_byte(d, 8'(op));
        for (int i = n - 1; i >= 0; i--) send_byte(d, 8'(a >> (8 * i)));
        if (op != 2) for (int i = n - 1; i >= 0; i--) send_byte(d, 8'(b >> (8 * i)));
    endtask

    task automatic wait_idle(input int d);
        bit done;
        done = 0;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clk);
            if (d == 0 && !busy8 && q8.size() == 0 && tx_ready8) done = 1;
            if (d == 1 && !busy16 && q16.size() == 0 && tx_ready16) done = 1;
        end
        checkOutput("idle_reached", done, 1);
    endtask

    // Monitor, 8-bit instance: every tx_start pops the next expected byte
    always @(negedge clk) begin
        if (!rst_n) begin
            started8 = 0;
        end else begin
            if (tx_start8) begin
                starts8++;
                checkOutput("tx_ready_at_start8", tx_ready8, 1);
                if (q8.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL unexpected_tx8: got byte 0x%0h, expected no transmission", tx_byte8);
                end else begin
                    e8 = q8.pop_front();
                    checkOutput("tx_byte8", tx_byte8, e8.data);
                    checkOutput("frame_done8", frame_done8, e8.last);
                end
                held8    = tx_byte8;
                started8 = 1;
            end else if (started8 && !tx_ready8) begin
                checkOutput("tx_byte_hold8", tx_byte8, held8);
            end
            if (err8) errs8++;
            if (frame_done8) frames8++;
        end
    end

    // Monitor, 16-bit instance
    always @(negedge clk) begin
        if (!rst_n) begin
            started16 = 0;
        end else begin
            if (tx_start16) begin
                starts16++;
                checkOutput("tx_ready_at_start16", tx_ready16, 1);
                if (q16.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL unexpected_tx16: got byte 0x%0h, expected no transmission", tx_byte16);
                end else begin
                    e16 = q16.pop_front();
                    checkOutput("tx_byte16", tx_byte16, e16.data);
                    checkOutput("frame_done16", frame_done16, e16.last);
                end
                held16    = tx_byte16;
                started16 = 1;
            end else if (started16 && !tx_ready16) begin
                checkOutput("tx_byte_hold16", tx_byte16, held16);
            end
            if (err16) errs16++;
            if (frame_done16) frames16++;
        end
    end

    // Transmitter emulation, 8-bit instance: busy for a random time, optionally stalled
    always begin
        @(negedge clk);
        if (rst_n && tx_start8) begin
            @(posedge clk); #1;
            tx_ready8 = 1'b0;
            repeat ($urandom_range(1, 4)) @(posedge clk);
            while (stall8) @(posedge clk);
            #1;
            tx_ready8 = 1'b1;
        end
    end

    // Transmitter emulation, 16-bit instance
    always begin
        @(negedge clk);
        if (rst_n && tx_start16) begin
            @(posedge clk); #1;
            tx_ready16 = 1'b0;
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
            tx_ready16 = 1'b1;
        end
    end

    initial begin
        int     found, s0;
        int     d, op;
        longint a, b;

        exp_frames[0] = 0; exp_frames[1] = 0;
        exp_errs[0]   = 0; exp_errs[1]   = 0;

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rst_tx_byte8", tx_byte8, 0);
        checkOutput("rst_tx_start8", tx_start8, 0);
        checkOutput("rst_busy8", busy8, 0);
        checkOutput("rst_frame_done8", frame_done8, 0);
        checkOutput("rst_err8", err8, 0);
        checkOutput("rst_tx_byte16", tx_byte16, 0);
        checkOutput("rst_busy16", busy16, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // First frame also checks latency: MUL cycle, then tx_start in TX_HDR
        applyStimulus(0, 0, 8'h0F, 8'h11);
        @(negedge clk);
        checkOutput("latency_mul_no_start", tx_start8, 0);
        @(negedge clk);
        checkOutput("latency_hdr_start", tx_start8, 1);
        wait_idle(0);
        checkOutput("frames_after_first", frames8, 1);

        applyStimulus(0, 1, 8'hFF, 8'h02); wait_idle(0);
        applyStimulus(0, 1, 8'h80, 8'h80); wait_idle(0);
        applyStimulus(0, 0, 8'hFF, 8'hFF); wait_idle(0);
        applyStimulus(0, 2, 8'h80, 8'h00); wait_idle(0);

        applyStimulus(1, 2, 16'h1234, 0);      wait_idle(1);
        applyStimulus(1, 1, 16'h8000, 16'h8000); wait_idle(1);
        applyStimulus(1, 0, 16'hFFFF, 16'hFFFF); wait_idle(1);
        applyStimulus(1, 1, 16'hFFFF, 16'h0002); wait_idle(1);

        // Bad opcode: error response without frame_done, then a normal frame
        push(0, 8'h5A, 0);
        push(0, 8'hEE, 0);
        exp_errs[0]++;
        send_byte(0, 8'hA5);
        send_byte(0, 8'h07);
        wait_idle(0);
        checkOutput("bad_opcode_err", errs8, exp_errs[0]);
        applyStimulus(0, 0, 8'h12, 8'h34); wait_idle(0);

        // Timeout after a partial request
        exp_errs[0]++;
        s0 = starts8;
        send_byte(0, 8'hA5);
        send_byte(0, 8'h00);
        send_byte(0, 8'h0F);
        found = 0;
        for (int k = 1; k <= 40 && found == 0; k++) begin
            @(negedge clk);
            if (err8) found = k;
        end
        checkOutput("timeout_cycles", found, 16);
        @(negedge clk);
        checkOutput("timeout_busy", busy8, 0);
        repeat (5) @(negedge clk);
        checkOutput("timeout_no_tx", starts8 - s0, 0);
        checkOutput("timeout_err", errs8, exp_errs[0]);

        // A byte landing exactly on the expiry cycle is accepted
        push_frame(0, 0, 8'h03, 8'h05);
        send_byte(0, 8'hA5);
        send_byte(0, 8'h00);
        repeat (14) @(posedge clk);
        send_byte(0, 8'h03);
        send_byte(0, 8'h05);
        wait_idle(0);
        checkOutput("expiry_accept_err", errs8, exp_errs[0]);

        // tx_ready held low during TX_DAT with stray rx bytes
        stall8 = 1;
        s0 = starts8;
        applyStimulus(0, 1, 8'hC3, 8'h3C);
        for (int k = 0; k < 20 && starts8 == s0; k++) @(negedge clk);
        s0 = starts8;
        send_byte(0, 8'hA5);
        send_byte(0, 8'h00);
        send_byte(0, 8'h01);
        send_byte(0, 8'h01);
        for (int k = 0; k < 6; k++) send_byte(0, 8'($urandom));
        repeat (30) @(posedge clk);
        checkOutput("stall_no_start", starts8 - s0, 0);
        stall8 = 0;
        wait_idle(0);
        repeat (5) @(negedge clk);
        checkOutput("stray_ignored_busy", busy8, 0);

        // Reset in the middle of TX_DAT
        stall8 = 1;
        s0 = starts8;
        applyStimulus(0, 1, 8'h7F, 8'h81);
        for (int k = 0; k < 20 && starts8 == s0; k++) @(negedge clk);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_tx_byte", tx_byte8, 0);
        checkOutput("midrst_tx_start", tx_start8, 0);
        checkOutput("midrst_busy", busy8, 0);
        checkOutput("midrst_frame_done", frame_done8, 0);
        checkOutput("midrst_err", err8, 0);
        q8.delete();
        exp_frames[0]--;
        @(posedge clk); #1;
        rst_n = 1'b1;
        stall8 = 0;
        s0 = starts8;
        repeat (40) @(posedge clk);
        checkOutput("postrst_no_start", starts8 - s0, 0);
        checkOutput("postrst_busy", busy8, 0);

        // Randomized frames on both instances
        for (int i = 0; i < 24; i++) begin
            d  = i % 2;
            op = $urandom_range(0, 2);
            a  = longint'($urandom) & ((d == 0) ? 64'hFF : 64'hFFFF);
            b  = longint'($urandom) & ((d == 0) ? 64'hFF : 64'hFFFF);
            applyStimulus(d, op, a, b);
            wait_idle(d);
        end

        checkOutput("frames8_total", frames8, exp_frames[0]);
        checkOutput("frames16_total", frames16, exp_frames[1]);
        checkOutput("errs8_total", errs8, exp_errs[0]);
        checkOutput("errs16_total", errs16, exp_errs[1]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
